// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for a clocked ALU: accepts one op, issues it, waits ALU_LATENCY edges, returns the result.
// Latency: response valid ALU_LATENCY+1 cycles after accept; one command in flight, period ALU_LATENCY+3.
// Backpressure: cmd_ready low outside IDLE; response held stable until rsp_ready. Optional: ALU_SEQ_ERR_CHECK_EN.
module alu_cmd_sequencer #(
    parameter int DATA_W      = 3,
    parameter int OP_W        = 4,
    parameter int RES_W       = 6,
    parameter int ALU_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [RES_W-1:0]  alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0] state;
    logic [2:0] cnt;
    logic       err_pend;
    logic       illegal;
    logic       accept;

    assign accept = cmd_valid & cmd_ready;

    always_comb begin
        illegal = 1'b0;
`ifdef ALU_SEQ_ERR_CHECK_EN
        illegal = (cmd_op == '0) || (cmd_op > OP_W'(12));
`endif
    end

    // Handshake outputs are registered so they read 0 while reset is held
    // and only rise on the first edge after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            err_pend   <= 1'b0;
            cmd_ready  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state     <= S_WAIT;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b0 | 1'b1;
                        cnt       <= 3'(ALU_LATENCY);
                        err_pend  <= illegal;
                        if (!illegal) begin
                            alu_a      <= cmd_a;
                            alu_b      <= cmd_b;
                            alu_opcode <= cmd_op;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (err_pend) begin
                        // Rejected opcode never reached the ALU; answer immediately.
                        err_pend  <= 1'b0;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        rsp_data  <= alu_result;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state      <= S_IDLE;
                        rsp_valid  <= 1'b0;
                        busy       <= 1'b0;
                        cmd_ready  <= 1'b1;
                        alu_opcode <= '0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    rsp_valid  <= 1'b0;
                    busy       <= 1'b0;
                    cmd_ready  <= 1'b0;
                    alu_opcode <= '0;
                end
            endcase
        end
    end

endmodule
